center_lock_detector: RTL and testbench
=======================================

Name: center_lock_detector

Overview:
- Downstream consumer of the gravity-center stage.
- Takes the per-cycle centroid stream (that stage's ready/Xc/Yc) and declares a "lock" once the centroid stays within a tolerance window for HOLD consecutive samples.
- Emits lock/unlock events through a small first-word-fall-through event FIFO with a valid/ready handshake to the host side.

Parameters:
- TOL, 2, max allowed per-axis absolute deviation from reference point (0..255)
- HOLD, 4, consecutive in-tolerance samples (reference included) required to lock; legal range 2..15
- DEPTH, 4, event FIFO entries; power of 2, 2..16

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  centroid sample valid (driven by upstream ready)
- in_x  input  8  centroid X
- in_y  input  8  centroid Y
- locked  output  1  registered lock status
- ev_valid  output  1  FIFO head valid
- ev_ready  input  1  consumer accepts head
- ev_x  output  8  event X
- ev_y  output  8  event Y
- ev_lock  output  1  1 = lock event, 0 = unlock event
- overflow  output  1  sticky: an event was dropped

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; ref_x, ref_y, cnt=0; FIFO emptied.
  - locked=0, ev_valid=0, ev_x=ev_y=0, ev_lock=0, overflow=0.
- Deviation check:
  - dx=|in_x-ref_x|, dy=|in_y-ref_y|, unsigned 8-bit, no wrap (9-bit subtract, then abs).
  - in_tol = (dx<=TOL) && (dy<=TOL).
- FSM transitions (evaluated only on edges with in_valid=1; in_valid=0 holds all state):
  - IDLE: ref<=in; cnt<=1; go TRACK.
  - TRACK, in_tol, cnt+1==HOLD: go LOCKED; locked<=1; push {ref_x, ref_y, 1}; cnt<=HOLD.
  - TRACK, in_tol, otherwise: cnt<=cnt+1.
  - TRACK, !in_tol: ref<=in; cnt<=1; no event.
  - LOCKED, in_tol: no change. The reference is frozen; no re-centering.
  - LOCKED, !in_tol: go TRACK; locked<=0; push {in_x, in_y, 0}; ref<=in; cnt<=1.
- Latency:
  - locked and FIFO push take effect at the same edge that samples the triggering in_valid.
  - ev_valid is visible in the following cycle (FWFT).
- Event FIFO:
  - ev_* reflect the head entry when non-empty; all zero when empty.
  - Pop on edge where ev_valid && ev_ready.
  - Push while full with no simultaneous pop: event dropped, FIFO unchanged, overflow<=1 (sticky until rst).
  - Push while full with simultaneous pop: both occur; count unchanged; no overflow.
  - Push while empty: ev_valid rises next cycle; a pop cannot occur that edge.
  - ev_x/ev_y/ev_lock stable while ev_valid=1 && ev_ready=0.
  - Pointers wrap modulo DEPTH; separate count register (0..DEPTH) distinguishes full from empty.
- Reset mid-operation: all state discarded immediately, including queued events; no partial event is ever emitted.

Optional Feature:
- Macro: CENTER_LOCK_ZERO_IGNORE_EN.
- Defined: samples with in_x==0 && in_y==0 are treated as in_valid=0. This covers the upstream zero-weight output, which must not break or form a lock.
- Undefined: (0,0) is processed as an ordinary sample.

Test Plan:
- Reset, then samples (100,50),(101,49),(102,51),(99,50) -> locked=1 after 4th edge; next cycle ev_valid=1, ev_x=100, ev_y=50, ev_lock=1.
- Continue from locked, sample (110,50) -> locked=0; second event (110,50,0). Then (111,50),(109,51) -> no lock; one more (110,52) -> lock event (110,50,1).
- Reset, then (100,50),(101,50),(104,50),(104,50),(103,51),(105,49) -> no event after 3rd sample (ref re-seeded to 104). Lock event (104,50,1) only after 6th sample.
- ev_ready=0, generate 5 alternating lock/unlock events -> ev_valid=1, head = first event, overflow=1 after 5th. Then ev_ready=1 drains exactly 4 events in order, then ev_valid=0.
- FIFO full with ev_ready=1 on the same edge as a new event -> count stays 4, overflow stays 0, new event appears last in drain order.
- In LOCKED with 2 queued events, pulse rst mid-cycle -> locked, ev_valid, overflow drop to 0 asynchronously. With macro defined, later samples (0,0)x4 produce no lock and state remains IDLE.

Source files
------------

// File: rtl/center_lock_detector_if.sv
// center_lock_detector_if
// Event channel between the lock detector and the host. The detector drives
// the head of its event queue; the host answers with ev_ready.
//   ev_valid  head entry present
//   ev_ready  host accepts the head entry this cycle
//   ev_x      event X coordinate
//   ev_y      event Y coordinate
//   ev_lock   1 = lock event, 0 = unlock event
// Modports: master = event producer (detector), slave = event consumer (host).
interface center_lock_detector_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_x;
  logic [7:0] ev_y;
  logic       ev_lock;

  modport master (
    output ev_valid,
    output ev_x,
    output ev_y,
    output ev_lock,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_x,
    input  ev_y,
    input  ev_lock,
    output ev_ready
  );
endinterface

// File: rtl/center_lock_detector.sv
// center_lock_detector
// Watches the centroid stream from the gravity-center stage and declares a
// lock once the centroid stays within +/-TOL of a reference point for HOLD
// consecutive samples (reference sample included). Lock and unlock events are
// queued in a small first-word-fall-through FIFO drained by the host.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  centroid sample valid
//   in_x/in_y centroid coordinates
//   locked    registered lock status
//   overflow  sticky flag: an event was dropped because the queue was full
//   ev        event channel (center_lock_detector_if.master)
// Parameters: TOL (0..255), HOLD (2..15), DEPTH (power of 2, 2..16).
// Optional build macro: CENTER_LOCK_ZERO_IGNORE_EN -- when defined, (0,0)
// samples are ignored as if in_valid were low.
module center_lock_detector #(
  parameter int TOL   = 2,
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_x,
  input  logic [7:0]              in_y,
  output logic                    locked,
  output logic                    overflow,
  center_lock_detector_if.master  ev
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [8:0]    TOL_V    = 9'(TOL);
  localparam logic [4:0]    HOLD_V   = 5'(HOLD);
  localparam logic [3:0]    HOLD_CNT = 4'(HOLD);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  state_t      state;
  logic [7:0]  ref_x;
  logic [7:0]  ref_y;
  logic [3:0]  cnt;

  logic        sample;
  logic [8:0]  diff_x;
  logic [8:0]  diff_y;
  logic [8:0]  dx;
  logic [8:0]  dy;
  logic        in_tol;
  logic        hold_reached;

  logic        push;
  logic [16:0] push_entry;

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_push;

  // The upstream zero-weight output reports (0,0); it must neither build nor
  // break a lock, so it is filtered out before the tracker sees it.
`ifdef CENTER_LOCK_ZERO_IGNORE_EN
  assign sample = in_valid && !((in_x == 8'd0) && (in_y == 8'd0));
`else
  assign sample = in_valid;
`endif

  // 9-bit subtraction keeps the sign so the absolute value never wraps.
  assign diff_x = {1'b0, in_x} - {1'b0, ref_x};
  assign diff_y = {1'b0, in_y} - {1'b0, ref_y};
  assign dx     = diff_x[8] ? (9'd0 - diff_x) : diff_x;
  assign dy     = diff_y[8] ? (9'd0 - diff_y) : diff_y;
  assign in_tol = (dx <= TOL_V) && (dy <= TOL_V);

  assign hold_reached = (({1'b0, cnt}) + 5'd1) == HOLD_V;

  // Event generation mirrors the lock/unlock transitions of the tracker so
  // the queue write lands on the same edge as the locked change.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (sample) begin
      if ((state == TRACK) && in_tol && hold_reached) begin
        push       = 1'b1;
        push_entry = {ref_x, ref_y, 1'b1};
      end else if ((state == LOCKED) && !in_tol) begin
        push       = 1'b1;
        push_entry = {in_x, in_y, 1'b0};
      end
    end
  end

  // Tracker FSM. The reference is frozen once locked; a departure reseeds it
  // from the offending sample so tracking restarts there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ref_x  <= 8'd0;
      ref_y  <= 8'd0;
      cnt    <= 4'd0;
      locked <= 1'b0;
    end else if (sample) begin
      case (state)
        IDLE: begin
          ref_x <= in_x;
          ref_y <= in_y;
          cnt   <= 4'd1;
          state <= TRACK;
        end
        TRACK: begin
          if (in_tol) begin
            if (hold_reached) begin
              state  <= LOCKED;
              locked <= 1'b1;
              cnt    <= HOLD_CNT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else begin
            ref_x <= in_x;
            ref_y <= in_y;
            cnt   <= 4'd1;
          end
        end
        LOCKED: begin
          if (!in_tol) begin
            state  <= TRACK;
            locked <= 1'b0;
            ref_x  <= in_x;
            ref_y  <= in_y;
            cnt    <= 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = !empty && ev.ev_ready;
  assign do_push = push && (!full || pop);

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !do_push) begin
        count <= count - CW'(1);
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign ev.ev_valid = !empty;
  assign {ev.ev_x, ev.ev_y, ev.ev_lock} = empty ? 17'd0 : mem[rd_ptr];

endmodule

// File: tb/tb_center_lock_detector.sv
// tb_center_lock_detector
// Directed bench for center_lock_detector (TOL=2, HOLD=4, DEPTH=4). Walks
// through locking, unlocking, reference reseeding, queue overflow, full-queue
// push with simultaneous pop, and asynchronous reset while locked.
// Honours CENTER_LOCK_ZERO_IGNORE_EN for the (0,0) sample expectations.
module tb_center_lock_detector;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       locked;
  logic       overflow;

  int checks;
  int passes;

  center_lock_detector_if ev_bus ();

  center_lock_detector #(
    .TOL   (2),
    .HOLD  (4),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_x     (in_x),
    .in_y     (in_y),
    .locked   (locked),
    .overflow (overflow),
    .ev       (ev_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] evVec(input logic v, input logic [7:0] x,
                                        input logic [7:0] y, input logic l);
    return {14'd0, v, x, y, l};
  endfunction

  function automatic logic [31:0] evObserved();
    return {14'd0, ev_bus.ev_valid, ev_bus.ev_x, ev_bus.ev_y, ev_bus.ev_lock};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // One valid sample, presented just after an edge and consumed by the next.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Check the head entry, then pop it with a one-cycle ev_ready pulse.
  task automatic popCheck(input string tag, input logic [7:0] x,
                          input logic [7:0] y, input logic l);
    checkOutput(tag, evObserved(), evVec(1'b1, x, y, l));
    ev_bus.ev_ready = 1'b1;
    @(posedge clk);
    #1;
    ev_bus.ev_ready = 1'b0;
  endtask

  // Fill the queue with lock(10,10), unlock(50,50), lock(50,50), unlock(90,90).
  task automatic fourEvents();
    for (int i = 0; i < 4; i++) applyStimulus(8'd10, 8'd10);
    applyStimulus(8'd50, 8'd50);
    for (int i = 0; i < 3; i++) applyStimulus(8'd50, 8'd50);
    applyStimulus(8'd90, 8'd90);
  endtask

  initial begin
    checks          = 0;
    passes          = 0;
    rst             = 1'b0;
    in_valid        = 1'b0;
    in_x            = 8'd0;
    in_y            = 8'd0;
    ev_bus.ev_ready = 1'b0;
    #2;

    // Reset state
    doReset();
    checkOutput("reset_locked", {31'd0, locked}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset_event", evObserved(), 32'd0);

    // Basic lock
    $display("[TB] basic lock");
    applyStimulus(8'd100, 8'd50);
    applyStimulus(8'd101, 8'd49);
    applyStimulus(8'd102, 8'd51);
    checkOutput("pre_lock_locked", {31'd0, locked}, 32'd0);
    checkOutput("pre_lock_event", evObserved(), 32'd0);
    applyStimulus(8'd99, 8'd50);
    checkOutput("lock1_locked", {31'd0, locked}, 32'd1);
    checkOutput("lock1_event", evObserved(), evVec(1'b1, 8'd100, 8'd50, 1'b1));
    applyStimulus(8'd102, 8'd52);
    checkOutput("frozen_ref_locked", {31'd0, locked}, 32'd1);

    // Unlock and relock around the new reference
    $display("[TB] unlock and relock");
    applyStimulus(8'd110, 8'd50);
    checkOutput("unlock_locked", {31'd0, locked}, 32'd0);
    checkOutput("unlock_head_held", evObserved(), evVec(1'b1, 8'd100, 8'd50, 1'b1));
    applyStimulus(8'd111, 8'd50);
    applyStimulus(8'd109, 8'd51);
    checkOutput("relock_pending", {31'd0, locked}, 32'd0);
    applyStimulus(8'd110, 8'd52);
    checkOutput("relock_locked", {31'd0, locked}, 32'd1);
    popCheck("drain2_e1", 8'd100, 8'd50, 1'b1);
    popCheck("drain2_e2", 8'd110, 8'd50, 1'b0);
    popCheck("drain2_e3", 8'd110, 8'd50, 1'b1);
    checkOutput("drain2_empty", evObserved(), 32'd0);

    // Reference reseed on an out-of-tolerance sample
    $display("[TB] reseed");
    doReset();
    applyStimulus(8'd100, 8'd50);
    applyStimulus(8'd101, 8'd50);
    applyStimulus(8'd104, 8'd50);
    checkOutput("reseed_no_event", evObserved(), 32'd0);
    applyStimulus(8'd104, 8'd50);
    applyStimulus(8'd103, 8'd51);
    checkOutput("reseed_not_locked", {31'd0, locked}, 32'd0);
    checkOutput("reseed_still_empty", evObserved(), 32'd0);
    applyStimulus(8'd105, 8'd49);
    checkOutput("reseed_locked", {31'd0, locked}, 32'd1);
    checkOutput("reseed_event", evObserved(), evVec(1'b1, 8'd104, 8'd50, 1'b1));

    // Overflow: five events into a four-entry queue
    $display("[TB] overflow");
    doReset();
    fourEvents();
    checkOutput("ovf_before", {31'd0, overflow}, 32'd0);
    checkOutput("ovf_head_first", evObserved(), evVec(1'b1, 8'd10, 8'd10, 1'b1));
    for (int i = 0; i < 3; i++) applyStimulus(8'd90, 8'd90);
    checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_locked", {31'd0, locked}, 32'd1);
    popCheck("ovf_e1", 8'd10, 8'd10, 1'b1);
    popCheck("ovf_e2", 8'd50, 8'd50, 1'b0);
    popCheck("ovf_e3", 8'd50, 8'd50, 1'b1);
    popCheck("ovf_e4", 8'd90, 8'd90, 1'b0);
    checkOutput("ovf_empty", evObserved(), 32'd0);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Full queue with simultaneous push and pop
    $display("[TB] full push with pop");
    doReset();
    fourEvents();
    applyStimulus(8'd90, 8'd90);
    applyStimulus(8'd90, 8'd90);
    ev_bus.ev_ready = 1'b1;
    applyStimulus(8'd90, 8'd90);
    ev_bus.ev_ready = 1'b0;
    checkOutput("pushpop_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("pushpop_locked", {31'd0, locked}, 32'd1);
    popCheck("pushpop_e2", 8'd50, 8'd50, 1'b0);
    popCheck("pushpop_e3", 8'd50, 8'd50, 1'b1);
    popCheck("pushpop_e4", 8'd90, 8'd90, 1'b0);
    popCheck("pushpop_e5", 8'd90, 8'd90, 1'b1);
    checkOutput("pushpop_empty", evObserved(), 32'd0);

    // Asynchronous reset while locked with queued events and overflow set
    $display("[TB] async reset");
    doReset();
    fourEvents();
    for (int i = 0; i < 3; i++) applyStimulus(8'd90, 8'd90);
    popCheck("arst_pop1", 8'd10, 8'd10, 1'b1);
    popCheck("arst_pop2", 8'd50, 8'd50, 1'b0);
    checkOutput("arst_pre_locked", {31'd0, locked}, 32'd1);
    checkOutput("arst_pre_overflow", {31'd0, overflow}, 32'd1);
    checkOutput("arst_pre_head", evObserved(), evVec(1'b1, 8'd50, 8'd50, 1'b1));
    #3;
    rst = 1'b1;
    #2;
    checkOutput("arst_locked", {31'd0, locked}, 32'd0);
    checkOutput("arst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("arst_event", evObserved(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // (0,0) samples after reset
    $display("[TB] zero samples");
    for (int i = 0; i < 4; i++) applyStimulus(8'd0, 8'd0);
`ifdef CENTER_LOCK_ZERO_IGNORE_EN
    checkOutput("zero_locked", {31'd0, locked}, 32'd0);
    checkOutput("zero_event", evObserved(), 32'd0);
    // Still in IDLE: the next sample seeds the reference, so three more
    // matching samples are needed for a lock.
    for (int i = 0; i < 3; i++) applyStimulus(8'd20, 8'd20);
    checkOutput("zero_idle_not_locked", {31'd0, locked}, 32'd0);
    applyStimulus(8'd20, 8'd20);
    checkOutput("zero_idle_lock", evObserved(), evVec(1'b1, 8'd20, 8'd20, 1'b1));
`else
    checkOutput("zero_locked", {31'd0, locked}, 32'd1);
    checkOutput("zero_event", evObserved(), evVec(1'b1, 8'd0, 8'd0, 1'b1));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
